// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the pulse-train transmitter: FSM encodings and
// the timer sizing helper.
package pulse_gen_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Bits needed to hold value-1; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pulse_train_gen_phase_timer.sv
// Loadable down-counter with a terminal-count flag. It stops at zero and
// holds there until the next load.
module phase_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Emits exactly `count` fixed-width high pulses, each followed by a full
// low gap, then strobes done. Drives a downstream rising-edge counter.
//
//   state | meaning
//   IDLE  | waiting for start; sent holds the last train's total
//   HIGH  | pulse_out high, timing HIGH_CYCLES
//   LOW   | pulse_out low, timing LOW_CYCLES gap after every pulse
//   DONE  | one-cycle done strobe, then back to IDLE
module pulse_train_gen
  import pulse_gen_pkg::*;
#(
  parameter int N_BITS      = 4,
  parameter int HIGH_CYCLES = 2,
  parameter int LOW_CYCLES  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_BITS-1:0] count,
  output logic              pulse_out,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] sent
);

  localparam int TW = clog2((HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES) + 1;
  localparam logic [TW-1:0] H_LOAD = TW'(HIGH_CYCLES - 1);
  localparam logic [TW-1:0] L_LOAD = TW'(LOW_CYCLES - 1);

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [N_BITS-1:0] cnt_lat;
  logic              tmr_load;
  logic [TW-1:0]     tmr_val;
  logic              tmr_zero;

  phase_timer #(.WIDTH(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_nx = state;
    tmr_load = 1'b0;
    tmr_val  = H_LOAD;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (count != '0) begin
            state_nx = ST_HIGH;
            tmr_load = 1'b1;
          end else begin
            state_nx = ST_DONE;
          end
        end
      end
      ST_HIGH: begin
        if (tmr_zero) begin
          state_nx = ST_LOW;
          tmr_load = 1'b1;
          tmr_val  = L_LOAD;
        end
      end
      ST_LOW: begin
        if (tmr_zero) begin
          if (sent == cnt_lat) begin
            state_nx = ST_DONE;
          end else begin
            state_nx = ST_HIGH;
            tmr_load = 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt_lat   <= '0;
      sent      <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      pulse_out <= (state_nx == ST_HIGH);
      busy      <= (state_nx == ST_HIGH) || (state_nx == ST_LOW);
      done      <= (state_nx == ST_DONE);
      if (state == ST_IDLE && start) begin
        sent <= '0;
        if (count != '0) cnt_lat <= count;
      end
      // Count on the falling edge of pulse_out, matching a downstream edge counter.
      if (state == ST_HIGH && tmr_zero) begin
        sent <= sent + N_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench: expected per-cycle traces derived from count/HIGH/LOW
// are queued at launch and compared cycle by cycle against the DUTs.
module tb_pulse_train_gen;

  typedef struct packed {
    logic       p;
    logic       b;
    logic       d;
    logic [3:0] s;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0;
  logic [3:0] count_a = 4'd0;
  logic       pulse_a, busy_a, done_a;
  logic [3:0] sent_a;
  logic       start_b = 1'b0;
  logic [3:0] count_b = 4'd0;
  logic       pulse_b, busy_b, done_b;
  logic [3:0] sent_b;

  logic [3:0] edge_cnt;
  logic       pulse_prev;
  logic       clr_ec = 1'b0;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pulse_train_gen #(.N_BITS(4), .HIGH_CYCLES(2), .LOW_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .count(count_a),
    .pulse_out(pulse_a), .busy(busy_a), .done(done_a), .sent(sent_a)
  );

  pulse_train_gen #(.N_BITS(4), .HIGH_CYCLES(1), .LOW_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .count(count_b),
    .pulse_out(pulse_b), .busy(busy_b), .done(done_b), .sent(sent_b)
  );

  // Downstream 4-bit rising-edge counter on dut_a's line
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt   <= 4'd0;
      pulse_prev <= 1'b0;
    end else begin
      pulse_prev <= pulse_a;
      if (clr_ec) edge_cnt <= 4'd0;
      else if (pulse_a && !pulse_prev) edge_cnt <= edge_cnt + 4'd1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic push_train(input int n, input int h, input int l);
    exp_t e;
    for (int k = 0; k < n * (h + l); k++) begin
      e.p = ((k % (h + l)) < h);
      e.b = 1'b1;
      e.d = 1'b0;
      e.s = (k >= h) ? 4'((k - h) / (h + l) + 1) : 4'd0;
      exp_q.push_back(e);
    end
    e = '{p: 1'b0, b: 1'b0, d: 1'b1, s: 4'(n)};
    exp_q.push_back(e);
    e = '{p: 1'b0, b: 1'b0, d: 1'b0, s: 4'(n)};
    exp_q.push_back(e);
  endtask

  task automatic launch(input bit sel, input logic [3:0] n);
    @(posedge clk);
    #1;
    if (sel) begin start_b = 1'b1; count_b = n; end
    else     begin start_a = 1'b1; count_a = n; end
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic drain(input bit sel, input int inj_idx, input logic [3:0] inj_cnt,
                       input bit chk_loop, output int busy_cycles);
    int i;
    exp_t e;
    exp_t o;
    i = 0;
    busy_cycles = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      if (sel) o = {pulse_b, busy_b, done_b, sent_b};
      else     o = {pulse_a, busy_a, done_a, sent_a};
      if (o.b) busy_cycles++;
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL trace sel=%0d cyc=%0d got p=%b b=%b d=%b s=%0d want p=%b b=%b d=%b s=%0d",
                 sel, i + 1, o.p, o.b, o.d, o.s, e.p, e.b, e.d, e.s);
      end
      if (chk_loop && e.d) begin
        n_cmp++;
        if (edge_cnt !== e.s) begin
          n_bad++;
          $display("FAIL loopback_edge_count got %0d want %0d", edge_cnt, e.s);
        end
      end
      if (i == inj_idx) begin
        start_a = 1'b1;
        count_a = inj_cnt;
      end else if (i == inj_idx + 1) begin
        start_a = 1'b0;
      end
      i++;
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({pulse_a, busy_a, done_a, sent_a, pulse_b, busy_b, done_b, sent_b} !== 14'd0) begin
      n_bad++;
      $display("FAIL reset_values got a=%b%b%b/%0d b=%b%b%b/%0d want all 0",
               pulse_a, busy_a, done_a, sent_a, pulse_b, busy_b, done_b, sent_b);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int bc;
    push_train(3, 2, 1);
    launch(1'b0, 4'd3);
    drain(1'b0, -5, 4'd0, 1'b0, bc);
    n_cmp++;
    if (bc !== 9) begin
      n_bad++;
      $display("FAIL basic_busy_cycles got %0d want 9", bc);
    end
  endtask

  task automatic test_loopback();
    int bc;
    @(negedge clk) clr_ec = 1'b1;
    @(negedge clk) clr_ec = 1'b0;
    push_train(5, 2, 1);
    launch(1'b0, 4'd5);
    drain(1'b0, -5, 4'd0, 1'b1, bc);
  endtask

  task automatic test_zero();
    int bc;
    push_train(0, 2, 1);
    launch(1'b0, 4'd0);
    drain(1'b0, -5, 4'd0, 1'b0, bc);
    n_cmp++;
    if (bc !== 0) begin
      n_bad++;
      $display("FAIL zero_busy_cycles got %0d want 0", bc);
    end
  endtask

  task automatic test_ignored_start();
    int bc;
    push_train(2, 2, 1);
    launch(1'b0, 4'd2);
    drain(1'b0, 2, 4'd7, 1'b0, bc);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if (busy_a !== 1'b0 || pulse_a !== 1'b0 || sent_a !== 4'd2) begin
        n_bad++;
        $display("FAIL ignored_start_idle got b=%b p=%b s=%0d want b=0 p=0 s=2",
                 busy_a, pulse_a, sent_a);
      end
    end
  endtask

  task automatic test_max_length();
    int bc;
    push_train(15, 1, 1);
    launch(1'b1, 4'd15);
    drain(1'b1, -5, 4'd0, 1'b0, bc);
    n_cmp++;
    if (bc !== 30) begin
      n_bad++;
      $display("FAIL max_busy_cycles got %0d want 30", bc);
    end
  endtask

  task automatic test_back_to_back();
    int bc;
    for (int r = 0; r < 3; r++) begin
      logic [3:0] n;
      n = 4'($urandom_range(1, 6));
      push_train(int'(n), 1, 1);
      launch(1'b1, n);
      drain(1'b1, -5, 4'd0, 1'b0, bc);
    end
  endtask

  task automatic test_reset_mid();
    int bc;
    launch(1'b0, 4'd3);
    repeat (3) @(posedge clk);
    #3;
    n_cmp++;
    if (pulse_a !== 1'b1 || sent_a !== 4'd1) begin
      n_bad++;
      $display("FAIL reset_mid_precondition got p=%b s=%0d want p=1 s=1", pulse_a, sent_a);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (pulse_a !== 1'b0 || busy_a !== 1'b0 || sent_a !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_mid_async got p=%b b=%b s=%0d want 0 0 0", pulse_a, busy_a, sent_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (done_a !== 1'b0 || pulse_a !== 1'b0 || busy_a !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_mid_quiet got d=%b p=%b b=%b want 0 0 0", done_a, pulse_a, busy_a);
      end
    end
    push_train(2, 2, 1);
    launch(1'b0, 4'd2);
    drain(1'b0, -5, 4'd0, 1'b0, bc);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_loopback();
    test_zero();
    test_ignored_start();
    test_max_length();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
